// File: rtl/ma_lsu_ctrl.sv
// Memory-access stage load/store controller: issues one data-memory request per load/store,
// stalls the pipeline until ACK or timeout, and forms the registered write-back.
module ma_lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iMEM,
  input  logic        iRW,
  input  logic [4:0]  iDecodedOP,
  input  logic [31:0] iADDR,
  input  logic [31:0] iWDATA,
  input  logic [4:0]  iDregADDR,
  input  logic [31:0] iDregDATA,
  input  logic        iDregWE,
  output logic        oStall,
  output logic [4:0]  oDregADDR,
  output logic [31:0] oDregDATA,
  output logic        oDregWE,
  output logic        oMisalign,
  output logic        oTimeout,
  output logic        oDmemREQ,
  output logic        oDmemWE,
  output logic [31:0] oDmemADDR,
  output logic [3:0]  oDmemBE,
  output logic [31:0] oDmemWDATA,
  input  logic        iDmemACK,
  input  logic [31:0] iDmemRDATA
);

  // Operation encodings; keep in sync with DecodedOP.vh.
  localparam logic [4:0] OpLb  = 5'd1;
  localparam logic [4:0] OpLh  = 5'd2;
  localparam logic [4:0] OpLw  = 5'd3;
  localparam logic [4:0] OpLbu = 5'd4;
  localparam logic [4:0] OpLhu = 5'd5;
  localparam logic [4:0] OpSb  = 5'd6;
  localparam logic [4:0] OpSh  = 5'd7;
  localparam logic [4:0] OpSw  = 5'd8;

  localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic [4:0]  r_op, w_op_d;
  logic [1:0]  r_lane, w_lane_d;
  logic [4:0]  r_dreg, w_dreg_d;

  logic        r_req, w_req_d;
  logic        r_mwe, w_mwe_d;
  logic [31:0] r_maddr, w_maddr_d;
  logic [3:0]  r_be, w_be_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic [4:0]  r_dadr, w_dadr_d;
  logic [31:0] r_ddat, w_ddat_d;
  logic        r_dwe, w_dwe_d;
  logic        r_mis, w_mis_d;
  logic        r_to, w_to_d;
  logic        w_stall;

  // Instruction decode for the op currently presented in IDLE.
  logic        w_is_load, w_is_store, w_legal, w_half, w_word, w_misal;
  logic [3:0]  w_be_new;
  logic [31:0] w_wdata_new;

  always_comb begin
    w_is_load  = (iDecodedOP == OpLb) || (iDecodedOP == OpLh) || (iDecodedOP == OpLw) ||
                 (iDecodedOP == OpLbu) || (iDecodedOP == OpLhu);
    w_is_store = (iDecodedOP == OpSb) || (iDecodedOP == OpSh) || (iDecodedOP == OpSw);
    w_legal    = (w_is_load && iRW) || (w_is_store && !iRW);
    w_half     = (iDecodedOP == OpLh) || (iDecodedOP == OpLhu) || (iDecodedOP == OpSh);
    w_word     = (iDecodedOP == OpLw) || (iDecodedOP == OpSw);
    w_misal    = (w_half && iADDR[0]) || (w_word && (iADDR[1:0] != 2'b00));
  end

  always_comb begin
    w_be_new    = 4'b1111;
    w_wdata_new = iWDATA;
    case (iDecodedOP)
      OpSb: begin
        w_be_new    = 4'b0001 << iADDR[1:0];
        w_wdata_new = {4{iWDATA[7:0]}};
      end
      OpSh: begin
        w_be_new    = 4'b0011 << {iADDR[1], 1'b0};
        w_wdata_new = {2{iWDATA[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection and extension of returned read data, using the captured op/address.
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_load_val;

  always_comb begin
    case (r_lane)
      2'd0:    w_rbyte = iDmemRDATA[7:0];
      2'd1:    w_rbyte = iDmemRDATA[15:8];
      2'd2:    w_rbyte = iDmemRDATA[23:16];
      default: w_rbyte = iDmemRDATA[31:24];
    endcase
    w_rhalf = r_lane[1] ? iDmemRDATA[31:16] : iDmemRDATA[15:0];
    case (r_op)
      OpLb:    w_load_val = {{24{w_rbyte[7]}}, w_rbyte};
      OpLbu:   w_load_val = {24'd0, w_rbyte};
      OpLh:    w_load_val = {{16{w_rhalf[15]}}, w_rhalf};
      OpLhu:   w_load_val = {16'd0, w_rhalf};
      default: w_load_val = iDmemRDATA;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_op_d    = r_op;
    w_lane_d  = r_lane;
    w_dreg_d  = r_dreg;
    w_req_d   = r_req;
    w_mwe_d   = r_mwe;
    w_maddr_d = r_maddr;
    w_be_d    = r_be;
    w_wdata_d = r_wdata;
    w_dadr_d  = r_dadr;
    w_ddat_d  = r_ddat;
    w_dwe_d   = 1'b0;
    w_mis_d   = 1'b0;
    w_to_d    = 1'b0;
    w_stall   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (!iMEM) begin
          w_dadr_d = iDregADDR;
          w_ddat_d = iDregDATA;
          w_dwe_d  = iDregWE && (iDregADDR != 5'd0);
        end else if (w_legal) begin
          if (w_misal) begin
            w_mis_d = 1'b1;
          end else begin
            w_stall   = 1'b1;
            w_state_d = StBusy;
            w_cnt_d   = 8'd0;
            w_op_d    = iDecodedOP;
            w_lane_d  = iADDR[1:0];
            w_dreg_d  = iDregADDR;
            w_req_d   = 1'b1;
            w_mwe_d   = w_is_store;
            w_maddr_d = {iADDR[31:2], 2'b00};
            w_be_d    = w_be_new;
            w_wdata_d = w_wdata_new;
          end
        end
      end
      StBusy: begin
        w_stall = 1'b1;
        if (iDmemACK) begin
          w_req_d   = 1'b0;
          w_state_d = StDone;
          if (!r_mwe) begin
            w_dadr_d = r_dreg;
            w_ddat_d = w_load_val;
            w_dwe_d  = (r_dreg != 5'd0);
          end
        end else if (r_cnt == LastWait) begin
          w_req_d   = 1'b0;
          w_to_d    = 1'b1;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
      r_op    <= 5'd0;
      r_lane  <= 2'd0;
      r_dreg  <= 5'd0;
      r_req   <= 1'b0;
      r_mwe   <= 1'b0;
      r_maddr <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_dadr  <= 5'd0;
      r_ddat  <= 32'd0;
      r_dwe   <= 1'b0;
      r_mis   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_op    <= w_op_d;
      r_lane  <= w_lane_d;
      r_dreg  <= w_dreg_d;
      r_req   <= w_req_d;
      r_mwe   <= w_mwe_d;
      r_maddr <= w_maddr_d;
      r_be    <= w_be_d;
      r_wdata <= w_wdata_d;
      r_dadr  <= w_dadr_d;
      r_ddat  <= w_ddat_d;
      r_dwe   <= w_dwe_d;
      r_mis   <= w_mis_d;
      r_to    <= w_to_d;
    end
  end

  // Stall is combinational, so it must also be forced low while reset is held.
  assign oStall     = w_stall && iRSTn;
  assign oDregADDR  = r_dadr;
  assign oDregDATA  = r_ddat;
  assign oDregWE    = r_dwe;
  assign oMisalign  = r_mis;
  assign oTimeout   = r_to;
  assign oDmemREQ   = r_req;
  assign oDmemWE    = r_mwe;
  assign oDmemADDR  = r_maddr;
  assign oDmemBE    = r_be;
  assign oDmemWDATA = r_wdata;

endmodule

// File: tb/tb_ma_lsu_ctrl.sv
// Bench for ma_lsu_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model.
module tb_ma_lsu_ctrl;

  localparam int unsigned MaxWait = 4;
  localparam logic [4:0] LB = 5'd1, LH = 5'd2, LW = 5'd3, LBU = 5'd4, LHU = 5'd5;
  localparam logic [4:0] SB = 5'd6, SH = 5'd7, SW = 5'd8;

  logic        iCLK = 1'b0;
  logic        iRSTn = 1'b0;
  logic        iMEM = 1'b0;
  logic        iRW = 1'b0;
  logic [4:0]  iDecodedOP = 5'd0;
  logic [31:0] iADDR = 32'd0;
  logic [31:0] iWDATA = 32'd0;
  logic [4:0]  iDregADDR = 5'd0;
  logic [31:0] iDregDATA = 32'd0;
  logic        iDregWE = 1'b0;
  logic        iDmemACK = 1'b0;
  logic [31:0] iDmemRDATA = 32'd0;

  logic        oStall, oDregWE, oMisalign, oTimeout, oDmemREQ, oDmemWE;
  logic [4:0]  oDregADDR;
  logic [31:0] oDregDATA, oDmemADDR, oDmemWDATA;
  logic [3:0]  oDmemBE;

  int tests = 0;
  int fails = 0;

  ma_lsu_ctrl #(.MAX_WAIT(MaxWait)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iMEM(iMEM), .iRW(iRW), .iDecodedOP(iDecodedOP),
    .iADDR(iADDR), .iWDATA(iWDATA), .iDregADDR(iDregADDR), .iDregDATA(iDregDATA),
    .iDregWE(iDregWE), .oStall(oStall), .oDregADDR(oDregADDR), .oDregDATA(oDregDATA),
    .oDregWE(oDregWE), .oMisalign(oMisalign), .oTimeout(oTimeout), .oDmemREQ(oDmemREQ),
    .oDmemWE(oDmemWE), .oDmemADDR(oDmemADDR), .oDmemBE(oDmemBE), .oDmemWDATA(oDmemWDATA),
    .iDmemACK(iDmemACK), .iDmemRDATA(iDmemRDATA)
  );

  always #5 iCLK = ~iCLK;

  function automatic bit f_load(input logic [4:0] op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic bit f_store(input logic [4:0] op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic int f_size(input logic [4:0] op);
    if (op inside {LB, LBU, SB}) return 1;
    if (op inside {LH, LHU, SH}) return 2;
    return 4;
  endfunction

  function automatic bit f_legal(input logic [4:0] op, input logic rw);
    return (f_load(op) && rw) || (f_store(op) && !rw);
  endfunction

  function automatic bit f_aligned(input logic [4:0] op, input logic [31:0] a);
    return (int'(a[1:0]) % f_size(op)) == 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [4:0] op, input logic [31:0] a);
    logic [31:0] m;
    if (f_load(op)) return 4'hF;
    m = (32'd1 << f_size(op)) - 32'd1;
    return 4'(m << a[1:0]);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [4:0] op, input logic [31:0] wd);
    if (op == SB) return 32'(wd[7:0]) * 32'h0101_0101;
    if (op == SH) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] f_load_val(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz;
    logic [31:0] mask, v;
    sz = f_size(op);
    if (sz == 4) return rd;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (rd >> (8 * int'(a[1:0]))) & mask;
    if ((op == LB || op == LH) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  // Transaction-level model: one outstanding access, a wait tally, and a one-cycle wrap-up.
  bit          m_busy = 1'b0, m_done = 1'b0;
  int          m_wait = 0;
  logic [4:0]  m_op = 5'd0, m_dreg = 5'd0;
  logic [31:0] m_addr = 32'd0;
  logic        e_req = 1'b0, e_mwe = 1'b0, e_dwe = 1'b0, e_mis = 1'b0, e_to = 1'b0;
  logic [31:0] e_maddr = 32'd0, e_wdata = 32'd0, e_ddat = 32'd0;
  logic [3:0]  e_be = 4'd0;
  logic [4:0]  e_dadr = 5'd0;

  always @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_wait <= 0;
      e_req <= 1'b0; e_mwe <= 1'b0; e_maddr <= 32'd0; e_be <= 4'd0; e_wdata <= 32'd0;
      e_dwe <= 1'b0; e_dadr <= 5'd0; e_ddat <= 32'd0; e_mis <= 1'b0; e_to <= 1'b0;
    end else begin
      e_dwe <= 1'b0;
      e_mis <= 1'b0;
      e_to  <= 1'b0;
      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_busy) begin
        if (iDmemACK) begin
          m_busy <= 1'b0; m_done <= 1'b0 | 1'b1; e_req <= 1'b0;
          if (f_load(m_op)) begin
            e_dwe  <= (m_dreg != 5'd0);
            e_dadr <= m_dreg;
            e_ddat <= f_load_val(m_op, m_addr, iDmemRDATA);
          end
        end else if (m_wait + 1 >= int'(MaxWait)) begin
          m_busy <= 1'b0; m_done <= 1'b1; e_req <= 1'b0; e_to <= 1'b1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (!iMEM) begin
        e_dadr <= iDregADDR;
        e_ddat <= iDregDATA;
        e_dwe  <= iDregWE && (iDregADDR != 5'd0);
      end else if (f_legal(iDecodedOP, iRW)) begin
        if (!f_aligned(iDecodedOP, iADDR)) begin
          e_mis <= 1'b1;
        end else begin
          m_busy <= 1'b1; m_wait <= 0;
          m_op <= iDecodedOP; m_addr <= iADDR; m_dreg <= iDregADDR;
          e_req   <= 1'b1;
          e_mwe   <= f_store(iDecodedOP);
          e_maddr <= iADDR & ~32'h3;
          e_be    <= f_be(iDecodedOP, iADDR);
          e_wdata <= f_wdata(iDecodedOP, iWDATA);
        end
      end
    end
  end

  function automatic bit exp_stall();
    if (!iRSTn || m_done) return 1'b0;
    if (m_busy) return 1'b1;
    return iMEM && f_legal(iDecodedOP, iRW) && f_aligned(iDecodedOP, iADDR);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("stall", 32'(oStall), 32'(exp_stall()));
    chk("dmem_req", 32'(oDmemREQ), 32'(e_req));
    chk("dreg_we", 32'(oDregWE), 32'(e_dwe));
    chk("misalign", 32'(oMisalign), 32'(e_mis));
    chk("timeout", 32'(oTimeout), 32'(e_to));
    if (e_req) begin
      chk("dmem_addr", oDmemADDR, e_maddr);
      chk("dmem_be", 32'(oDmemBE), 32'(e_be));
      chk("dmem_we", 32'(oDmemWE), 32'(e_mwe));
      if (e_mwe) chk("dmem_wdata", oDmemWDATA, e_wdata);
    end
    if (e_dwe) begin
      chk("dreg_addr", 32'(oDregADDR), 32'(e_dadr));
      chk("dreg_data", oDregDATA, e_ddat);
    end
  endtask

  task automatic settle();
    @(negedge iCLK);
    compare_all();
  endtask

  task automatic adv();
    @(posedge iCLK);
    #1;
  endtask

  task automatic rand_inputs();
    logic [31:0] a;
    iMEM       = 1'($urandom_range(0, 1));
    iDecodedOP = 5'($urandom_range(0, 10));
    iRW        = ($urandom_range(0, 7) == 0) ? !f_load(iDecodedOP) : f_load(iDecodedOP);
    a = $urandom;
    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    else if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
    iADDR      = a;
    iWDATA     = $urandom;
    iDregADDR  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    iDregDATA  = $urandom;
    iDregWE    = 1'($urandom_range(0, 1));
    iDmemACK   = ($urandom_range(0, 2) == 0);
    iDmemRDATA = $urandom;
  endtask

  initial begin
    // Reset held with a legal request presented: nothing may leak out.
    iMEM = 1'b1; iRW = 1'b1; iDecodedOP = LW; iADDR = 32'h0;
    adv(); adv();
    chk("rst_req", 32'(oDmemREQ), 32'd0);
    chk("rst_stall", 32'(oStall), 32'd0);
    chk("rst_dwe", 32'(oDregWE), 32'd0);
    chk("rst_ddat", oDregDATA, 32'd0);
    iMEM = 1'b0; iRSTn = 1'b1;
    settle(); adv();
    settle(); chk("post_rst_req", 32'(oDmemREQ), 32'd0); adv();

    // Passthrough.
    iDregADDR = 5'd5; iDregDATA = 32'hDEADBEEF; iDregWE = 1'b1;
    settle(); chk("pt_stall", 32'(oStall), 32'd0); adv();
    iDregWE = 1'b0;
    settle();
    chk("pt_addr", 32'(oDregADDR), 32'd5);
    chk("pt_data", oDregDATA, 32'hDEADBEEF);
    chk("pt_we", 32'(oDregWE), 32'd1);
    adv();

    // LB at 0x103, ACK one cycle after accept.
    iMEM = 1'b1; iRW = 1'b1; iDecodedOP = LB; iADDR = 32'h103; iDregADDR = 5'd7;
    settle(); chk("lb_stall_acc", 32'(oStall), 32'd1); adv();
    iDmemACK = 1'b1; iDmemRDATA = 32'h80112233;
    settle();
    chk("lb_req", 32'(oDmemREQ), 32'd1);
    chk("lb_addr", oDmemADDR, 32'h100);
    chk("lb_be", 32'(oDmemBE), 32'hF);
    chk("lb_stall_ack", 32'(oStall), 32'd1);
    adv();
    iDmemACK = 1'b0;
    settle();
    chk("lb_data", oDregDATA, 32'hFFFFFF80);
    chk("lb_dwe", 32'(oDregWE), 32'd1);
    chk("lb_dadr", 32'(oDregADDR), 32'd7);
    chk("lb_stall_done", 32'(oStall), 32'd0);
    chk("lb_req_drop", 32'(oDmemREQ), 32'd0);
    adv();
    iMEM = 1'b0;
    settle(); chk("lb_dwe_once", 32'(oDregWE), 32'd0); adv();

    // SH at 0x202, ACK in the third BUSY cycle; request fields must not follow the inputs.
    iMEM = 1'b1; iRW = 1'b0; iDecodedOP = SH; iADDR = 32'h202; iWDATA = 32'h0000ABCD;
    settle(); chk("sh_stall", 32'(oStall), 32'd1); adv();
    for (int k = 0; k < 3; k++) begin
      iADDR = $urandom; iWDATA = $urandom; iDmemACK = (k == 2);
      settle();
      chk("sh_req", 32'(oDmemREQ), 32'd1);
      chk("sh_addr", oDmemADDR, 32'h200);
      chk("sh_be", 32'(oDmemBE), 32'hC);
      chk("sh_wdata", oDmemWDATA, 32'hABCDABCD);
      chk("sh_we", 32'(oDmemWE), 32'd1);
      adv();
    end
    iDmemACK = 1'b0;
    settle();
    chk("sh_dwe", 32'(oDregWE), 32'd0);
    chk("sh_req_drop", 32'(oDmemREQ), 32'd0);
    adv();
    iMEM = 1'b0;

    // Misaligned LW.
    iMEM = 1'b1; iRW = 1'b1; iDecodedOP = LW; iADDR = 32'h301;
    settle(); chk("mis_stall", 32'(oStall), 32'd0); adv();
    iMEM = 1'b0;
    settle();
    chk("mis_pulse", 32'(oMisalign), 32'd1);
    chk("mis_req", 32'(oDmemREQ), 32'd0);
    chk("mis_dwe", 32'(oDregWE), 32'd0);
    adv();
    settle(); chk("mis_pulse_end", 32'(oMisalign), 32'd0); adv();

    // LHU without ACK: timeout after MaxWait request cycles.
    iMEM = 1'b1; iRW = 1'b1; iDecodedOP = LHU; iADDR = 32'h400;
    settle(); adv();
    for (int k = 0; k < int'(MaxWait); k++) begin
      settle();
      chk("to_req", 32'(oDmemREQ), 32'd1);
      chk("to_early", 32'(oTimeout), 32'd0);
      adv();
    end
    settle();
    chk("to_req_drop", 32'(oDmemREQ), 32'd0);
    chk("to_pulse", 32'(oTimeout), 32'd1);
    chk("to_dwe", 32'(oDregWE), 32'd0);
    adv();
    iMEM = 1'b0; iDregADDR = 5'd3; iDregDATA = 32'h1234; iDregWE = 1'b1;
    settle();
    chk("to_pulse_end", 32'(oTimeout), 32'd0);
    chk("to_idle_stall", 32'(oStall), 32'd0);
    adv();
    iDregWE = 1'b0;
    settle(); chk("to_idle_pt", 32'(oDregWE), 32'd1); adv();

    // Reset in the middle of BUSY, then a late ACK.
    iMEM = 1'b1; iRW = 1'b1; iDecodedOP = LW; iADDR = 32'h500;
    settle(); adv();
    settle(); chk("rstm_busy_req", 32'(oDmemREQ), 32'd1);
    iRSTn = 1'b0;
    #1;
    chk("rstm_req", 32'(oDmemREQ), 32'd0);
    chk("rstm_stall", 32'(oStall), 32'd0);
    adv();
    iRSTn = 1'b1; iMEM = 1'b0; iDmemACK = 1'b1; iDmemRDATA = 32'h5555AAAA; iDregWE = 1'b0;
    settle(); adv();
    iDmemACK = 1'b0;
    settle();
    chk("late_ack_req", 32'(oDmemREQ), 32'd0);
    chk("late_ack_dwe", 32'(oDregWE), 32'd0);
    adv();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      settle();
      adv();
      if (i % 397 == 396) begin
        #2;
        iRSTn = 1'b0;
        #1;
        compare_all();
        adv();
        iRSTn = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ma_lsu_ctrl.md
MA_LSU_CTRL -- requirements
Module: ma_lsu_ctrl

Interface
REQ-001 SHALL expose parameter MAX_WAIT, default 15, meaning maximum BUSY cycles without iDmemACK before timeout (range 1..255).
REQ-002 SHALL expose port iCLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL expose port iRSTn  in  1  asynchronous active-low reset.
REQ-004 SHALL expose port iMEM  in  1  memory transaction requested by current instruction.
REQ-005 SHALL expose port iRW  in  1  1 = read, 0 = write.
REQ-006 SHALL expose port iDecodedOP  in  5  operation code per DecodedOP.vh (`LB `LH `LW `LBU `LHU `SB `SH `SW).
REQ-007 SHALL expose ports iADDR  in  32  effective address; iWDATA  in  32  store data.
REQ-008 SHALL expose ports iDregADDR  in  5, iDregDATA  in  32, iDregWE  in  1  destination register address, passthrough data, write enable.
REQ-009 SHALL expose port oStall  out  1  freeze upstream pipeline (combinational).
REQ-010 SHALL expose ports oDregADDR  out  5, oDregDATA  out  32, oDregWE  out  1  registered write-back to WB stage.
REQ-011 SHALL expose ports oMisalign  out  1, oTimeout  out  1  registered one-cycle error pulses.
REQ-012 SHALL expose ports oDmemREQ  out  1, oDmemWE  out  1, oDmemADDR  out  32, oDmemBE  out  4, oDmemWDATA  out  32  data-memory request, all registered.
REQ-013 SHALL expose ports iDmemACK  in  1, iDmemRDATA  in  32  data-memory completion and read data (valid with ACK).

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE, iMEM=0: next edge oDregADDR<=iDregADDR, oDregDATA<=iDregDATA, oDregWE<=iDregWE&(iDregADDR!=0); oStall=0.
REQ-016 IDLE, iMEM=1, legal aligned op: capture op/dreg, go BUSY; next edge oDmemREQ=1, oDmemADDR={iADDR[31:2],2'b00}, oDmemWE=store; oStall=1 in accept cycle.
REQ-017 Legal op: loads require iRW=1, stores require iRW=0; any other op/iRW combination with iMEM=1 SHALL issue no request, oDregWE<=0, no stall, no error pulse.
REQ-018 Misaligned (H-ops addr[0]=1; W-ops addr[1:0]!=0) SHALL issue no request, oMisalign pulse 1 cycle, oDregWE<=0, no stall, remain IDLE.
REQ-019 Byte enables: loads 4'b1111; SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-020 Store data: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-021 BUSY: REQ/ADDR/BE/WE/WDATA SHALL stay stable until ACK; oStall=1 throughout, including ACK cycle.
REQ-022 BUSY with iDmemACK=1: REQ drops next edge, go DONE; loads register lane-selected data (LB/LH sign-, LBU/LHU zero-extended, byte at addr[1:0], half at addr[1]) into oDregDATA, oDregWE=(dreg!=0); stores oDregWE=0.
REQ-023 Wait counter SHALL clear on entering BUSY, increment per BUSY cycle without ACK; at MAX_WAIT, drop REQ, oTimeout pulse 1 cycle, go DONE with oDregWE=0.
REQ-024 DONE SHALL last exactly one cycle, oStall=0, iMEM ignored (same instruction still present), then IDLE.
REQ-025 Minimum load/store latency: accept cycle N, ACK in N+1, result valid in N+2; oStall high for N and N+1 only.
REQ-026 iDmemACK outside BUSY SHALL be ignored.
REQ-027 oDregWE SHALL be 0 in every cycle not driven by REQ-015 or REQ-022.

Reset
REQ-028 iRSTn=0 SHALL immediately force IDLE, counter 0, all outputs 0 (oDmemREQ drops asynchronously), including mid-BUSY.
REQ-029 Release of iRSTn SHALL take effect on next rising iCLK; no request issued in first post-reset cycle unless iMEM=1 in IDLE.

Verification
REQ-030 Passthrough: iMEM=0, iDregADDR=5, iDregDATA=0xDEADBEEF, iDregWE=1 -> next cycle oDregADDR=5, oDregDATA=0xDEADBEEF, oDregWE=1, oStall=0.
REQ-031 LB addr 0x103, ACK 1 cycle later with RDATA 0x80112233 -> oDmemADDR=0x100, BE=1111, oDregDATA=0xFFFFFF80, WE=1, stall 2 cycles.
REQ-032 SH addr 0x202, iWDATA=0x0000ABCD, ACK after 3 cycles -> BE=1100, WDATA=0xABCDABCD, WE=1 held stable until ACK, oDregWE=0.
REQ-033 LW addr 0x301 -> oMisalign=1 one cycle, oDmemREQ=0, oStall=0, oDregWE=0.
REQ-034 LHU addr 0x400, no ACK, MAX_WAIT=4 -> REQ high 4 cycles, oTimeout=1 one cycle, oDregWE=0, FSM IDLE two cycles later.
REQ-035 iRSTn=0 mid-BUSY -> oDmemREQ=0 and oStall=0 before next clock edge; late ACK after reset ignored.
